// File: rtl/ocra1_sched.sv
// ============================================================================
//  Module      : ocra1_sched
//  Description : Gradient-set sequencer in front of ocra1_iface. Runs the DAC
//                init burst after reset or on request, streams each X/Y/Z/Z2
//                set as four back-to-back 32-bit words, holds one set pending
//                and supervises the interface busy/data_lost handshake.
//                Optional counters enabled by OCRA1_SCHED_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ocra1_sched #(
    parameter int          BUSY_TIMEOUT = 256,
    parameter logic [23:0] INIT_WORD    = 24'h200002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_i,
    input  logic [17:0] vx_i,
    input  logic [17:0] vy_i,
    input  logic [17:0] vz_i,
    input  logic [17:0] vz2_i,
    input  logic        init_i,
    output logic [31:0] oc_data_o,
    output logic        oc_valid_o,
    input  logic        oc_busy_i,
    input  logic        oc_lost_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        overrun_o,
    output logic        err_o
`ifdef OCRA1_SCHED_CNT_EN
    ,
    output logic [15:0] sets_cnt_o,
    output logic [15:0] ovr_cnt_o
`endif
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_SEND = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         word_q, word_d;
    logic               is_init_q, is_init_d;
    logic               seen_q, seen_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic               init_req_q, init_req_d;
    logic               pend_q, pend_d;
    logic [3:0][17:0]   pvals_q, pvals_d;
    logic [3:0][17:0]   act_q, act_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic               err_q, err_d;
    logic               w_ovr_evt;
    logic               w_dispatch;
    logic               w_direct;
    logic [3:0][17:0]   w_in;
    logic [23:0]        w_payload;

    assign w_in = {vz2_i, vz_i, vy_i, vx_i};

    // State register and all sequencer bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_q     <= 2'd0;
            is_init_q  <= 1'b0;
            seen_q     <= 1'b0;
            tmo_q      <= '0;
            init_req_q <= 1'b1;
            pend_q     <= 1'b0;
            pvals_q    <= '0;
            act_q      <= '0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            is_init_q  <= is_init_d;
            seen_q     <= seen_d;
            tmo_q      <= tmo_d;
            init_req_q <= init_req_d;
            pend_q     <= pend_d;
            pvals_q    <= pvals_d;
            act_q      <= act_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: burst sequencing, busy supervision and pending slot
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        is_init_d  = is_init_q;
        seen_d     = seen_q;
        tmo_d      = tmo_q;
        init_req_d = init_req_q | init_i;
        pend_d     = pend_q;
        pvals_d    = pvals_q;
        act_d      = act_q;
        done_d     = 1'b0;
        ovr_d      = ovr_q;
        err_d      = err_q | oc_lost_i;
        w_ovr_evt  = 1'b0;
        w_dispatch = 1'b0;
        w_direct   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A same-cycle init strobe already wins over any set
                if (init_req_q || init_i) begin
                    state_d    = S_INIT;
                    word_d     = 2'd0;
                    is_init_d  = 1'b1;
                    seen_d     = 1'b0;
                    init_req_d = 1'b0;
                end else if (pend_q) begin
                    state_d    = S_SEND;
                    word_d     = 2'd0;
                    is_init_d  = 1'b0;
                    seen_d     = 1'b0;
                    act_d      = pvals_q;
                    w_dispatch = 1'b1;
                end else if (upd_i) begin
                    // Empty slot: the strobe goes straight to the wire
                    state_d   = S_SEND;
                    word_d    = 2'd0;
                    is_init_d = 1'b0;
                    seen_d    = 1'b0;
                    act_d     = w_in;
                    w_direct  = 1'b1;
                end
            end
            S_INIT, S_SEND: begin
                // The interface may raise busy while words are still arriving
                seen_d = seen_q | oc_busy_i;
                word_d = word_q + 2'd1;
                if (word_q == 2'd3) begin
                    state_d = S_WAIT;
                    tmo_d   = '0;
                end
            end
            default: begin
                seen_d = seen_q | oc_busy_i;
                tmo_d  = tmo_q + 1'b1;
                if (seen_q && !oc_busy_i) begin
                    state_d = S_IDLE;
                    done_d  = !is_init_q;
                end else if (tmo_q == CNT_W'(BUSY_TIMEOUT)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
        endcase

        if (upd_i && !w_direct) begin
            // Slot being emptied this cycle is not an overwrite
            if (pend_q && !w_dispatch) begin
                w_ovr_evt = 1'b1;
                ovr_d     = 1'b1;
            end
            pend_d  = 1'b1;
            pvals_d = w_in;
        end else if (w_dispatch) begin
            pend_d = 1'b0;
        end
    end

    // Word formatting straight from state so valid drops with reset
    always_comb begin
        w_payload  = is_init_q ? INIT_WORD : {4'h1, act_q[word_q], 2'b00};
        oc_valid_o = (state_q == S_INIT) || (state_q == S_SEND);
        oc_data_o  = oc_valid_o ? {5'd0, word_q, (word_q == 2'd3), w_payload} : 32'd0;
    end

    assign ready_o   = !pend_q;
    assign done_o    = done_q;
    assign overrun_o = ovr_q;
    assign err_o     = err_q;

`ifdef OCRA1_SCHED_CNT_EN
    logic [15:0] sets_cnt_q;
    logic [15:0] ovr_cnt_q;

    // Saturating event counters for completed sets and overwrites
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sets_cnt_q <= 16'd0;
            ovr_cnt_q  <= 16'd0;
        end else begin
            if (done_d && sets_cnt_q != 16'hFFFF) begin
                sets_cnt_q <= sets_cnt_q + 16'd1;
            end
            if (w_ovr_evt && ovr_cnt_q != 16'hFFFF) begin
                ovr_cnt_q <= ovr_cnt_q + 16'd1;
            end
        end
    end

    assign sets_cnt_o = sets_cnt_q;
    assign ovr_cnt_o  = ovr_cnt_q;
`endif

endmodule

`default_nettype wire
